// File: rtl/vpg_mode_sel.sv
// vpg_mode_sel: picks the video pattern generator mode from two debounced
// keys (next/prev) or a direct forced load, and stretches the change strobe
// so the downstream PLL reconfiguration sees a multi-cycle request.
module vpg_mode_sel #(
  parameter int CLK_DIV        = 8192,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int NUM_MODES      = 10,
  parameter int MODE_W         = 4,
  parameter int RESET_MODE     = 0,
  parameter int CHANGE_HOLD    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_next_n,
  input  logic              btn_prev_n,
  input  logic              mode_force_valid,
  input  logic [MODE_W-1:0] mode_force,
  output logic [MODE_W-1:0] vpg_mode,
  output logic              vpg_mode_change,
  output logic              tick_en
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(CHANGE_HOLD + 1);

  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DB_LAST    = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]     HOLD_LOAD  = HW'(CHANGE_HOLD);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RST   = MODE_W'(RESET_MODE);

  // Bit 0 is the next key, bit 1 the prev key throughout.
  logic [1:0]        key_raw;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        db_q, db_d;
  logic [1:0]        press_q, press_d;
  logic [DW-1:0]     cnt_q [2];
  logic [DW-1:0]     cnt_d [2];
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              force_ok;
  logic              upd;

  assign key_raw = {btn_prev_n, btn_next_n};

  // Prescaler wraps at CLK_DIV-1; tick is registered so it lands one cycle later.
  always_comb begin
    tick_d  = (presc_q == PRESC_LAST);
    presc_d = tick_d ? '0 : presc_q + PW'(1);
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Debounce per key on tick cycles; a flip towards 0 is the press event.
  always_comb begin
    db_d    = db_q;
    press_d = '0;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (tick_q) begin
        if (sync2_q[k] != db_q[k]) begin
          if (cnt_q[k] == DB_LAST) begin
            db_d[k]    = sync2_q[k];
            cnt_d[k]   = '0;
            press_d[k] = ~sync2_q[k];
          end else begin
            cnt_d[k] = cnt_q[k] + DW'(1);
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  // Two-flop synchronisers, debounced levels, counters and press events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      db_q     <= 2'b11;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Mode selection: an in-range force wins and swallows key events; clashing
  // next/prev events cancel; wraps use NUM_MODES-1, not the index width.
  always_comb begin
    mode_d   = mode_q;
    upd      = 1'b0;
    hold_d   = hold_q;
    force_ok = mode_force_valid && (mode_force <= MODE_LAST);
    if (force_ok) begin
      if (mode_force != mode_q) begin
        mode_d = mode_force;
        upd    = 1'b1;
      end
    end else if (press_q[0] && !press_q[1]) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
      upd    = 1'b1;
    end else if (press_q[1] && !press_q[0]) begin
      mode_d = (mode_q == '0) ? MODE_LAST : mode_q - MODE_W'(1);
      upd    = 1'b1;
    end
    if (upd) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  // Mode register and change-strobe down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_RST;
      hold_q <= '0;
    end else begin
      mode_q <= mode_d;
      hold_q <= hold_d;
    end
  end

  assign vpg_mode        = mode_q;
  assign vpg_mode_change = (hold_q != '0);
  assign tick_en         = tick_q;

endmodule

// File: tb/tb_vpg_mode_sel.sv
// Bench for vpg_mode_sel: a scoreboard of expected mode values is filled as
// stimulus is driven and drained by a monitor whenever vpg_mode moves.
module tb_vpg_mode_sel;

  localparam int CLK_DIV        = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int NUM_MODES      = 10;
  localparam int MODE_W         = 4;
  localparam int RESET_MODE     = 0;
  localparam int CHANGE_HOLD    = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              btn_next_n = 1'b1;
  logic              btn_prev_n = 1'b1;
  logic              mode_force_valid = 1'b0;
  logic [MODE_W-1:0] mode_force = '0;
  logic [MODE_W-1:0] vpg_mode;
  logic              vpg_mode_change;
  logic              tick_en;

  int tests_run = 0;
  int tests_failed = 0;

  logic [MODE_W-1:0] exp_q[$];
  logic [MODE_W-1:0] mon_exp;
  logic [MODE_W-1:0] prev_mode = MODE_W'(RESET_MODE);
  int exp_mode = RESET_MODE;
  int chg_run = 0;
  int chg_pulses = 0;
  int last_chg_len = 0;

  vpg_mode_sel #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .NUM_MODES(NUM_MODES),
    .MODE_W(MODE_W), .RESET_MODE(RESET_MODE), .CHANGE_HOLD(CHANGE_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_next_n(btn_next_n), .btn_prev_n(btn_prev_n),
    .mode_force_valid(mode_force_valid), .mode_force(mode_force),
    .vpg_mode(vpg_mode), .vpg_mode_change(vpg_mode_change), .tick_en(tick_en)
  );

  always #5 clk = ~clk;

  // Monitor: every observed mode change must match the next scoreboard entry;
  // also measures the length of each change-strobe pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (vpg_mode !== prev_mode) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_mode_change: got %0d, none expected", vpg_mode);
        end else begin
          mon_exp = exp_q.pop_front();
          if (vpg_mode !== mon_exp) begin
            tests_failed++;
            $display("FAIL mode_value: got %0d expected %0d", vpg_mode, mon_exp);
          end
        end
      end
      if (vpg_mode_change === 1'b1) begin
        chg_run++;
      end else if (chg_run != 0) begin
        last_chg_len = chg_run;
        chg_pulses++;
        chg_run = 0;
      end
    end else begin
      chg_run = 0;
    end
    prev_mode = vpg_mode;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_press(input bit nxt, input bit prv);
    if (nxt && !prv) begin
      exp_mode = (exp_mode + 1) % NUM_MODES;
      exp_q.push_back(MODE_W'(exp_mode));
    end else if (prv && !nxt) begin
      exp_mode = (exp_mode + NUM_MODES - 1) % NUM_MODES;
      exp_q.push_back(MODE_W'(exp_mode));
    end
  endtask

  task automatic press_key(input bit nxt, input bit prv, input int hold);
    model_press(nxt, prv);
    btn_next_n = ~nxt;
    btn_prev_n = ~prv;
    repeat (hold) step();
    btn_next_n = 1'b1;
    btn_prev_n = 1'b1;
    repeat (24) step();
  endtask

  task automatic do_force(input int v);
    @(posedge clk);
    #1;
    mode_force_valid = 1'b1;
    mode_force = MODE_W'(v);
    if (v < NUM_MODES && v != exp_mode) begin
      exp_mode = v;
      exp_q.push_back(MODE_W'(v));
    end
    @(posedge clk);
    #1;
    mode_force_valid = 1'b0;
  endtask

  task automatic settle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (exp_q.size() == 0 && vpg_mode_change === 1'b0) done = 1'b1;
      else step();
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_settle: pending=%0d strobe=%b, required 0 and 0", name, exp_q.size(), vpg_mode_change);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    check_int("reset_mode", int'(vpg_mode), RESET_MODE);
    check_int("reset_change", int'(vpg_mode_change), 0);
    check_int("reset_tick", int'(tick_en), 0);
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      check_int($sformatf("tick_cycle_%0d", cyc), int'(tick_en), (cyc % CLK_DIV == 0) ? 1 : 0);
      check_int($sformatf("idle_mode_%0d", cyc), int'(vpg_mode), RESET_MODE);
      check_int($sformatf("idle_change_%0d", cyc), int'(vpg_mode_change), 0);
    end
  endtask

  task automatic test_hold_next();
    int p0;
    int lat;
    p0 = chg_pulses;
    model_press(1'b1, 1'b0);
    btn_next_n = 1'b0;
    lat = 0;
    while (vpg_mode === MODE_W'(0) && lat < 40) begin
      step();
      lat++;
    end
    tests_run++;
    if (lat < 10 || lat > 16) begin
      tests_failed++;
      $display("FAIL next_latency: got %0d cycles, required 10..16", lat);
    end
    repeat (40 - lat) step();
    btn_next_n = 1'b1;
    repeat (24) step();
    settle("hold_next");
    check_int("hold_next_mode", int'(vpg_mode), 1);
    check_int("hold_next_pulses", chg_pulses - p0, 1);
    check_int("hold_next_strobe_len", last_chg_len, CHANGE_HOLD);
  endtask

  task automatic test_glitch_and_prev_wrap();
    int p0;
    p0 = chg_pulses;
    btn_prev_n = 1'b0;
    repeat (2 * CLK_DIV) step();
    btn_prev_n = 1'b1;
    repeat (16) step();
    check_int("glitch_mode", int'(vpg_mode), 1);
    check_int("glitch_pulses", chg_pulses - p0, 0);
    press_key(1'b0, 1'b1, 20);
    settle("prev1");
    check_int("prev_mode_0", int'(vpg_mode), 0);
    press_key(1'b0, 1'b1, 20);
    settle("prev_wrap");
    check_int("prev_wrap_mode", int'(vpg_mode), NUM_MODES - 1);
  endtask

  task automatic test_force_wrap();
    int p0;
    p0 = chg_pulses;
    do_force(9);
    repeat (10) step();
    check_int("force_equal_pulses", chg_pulses - p0, 0);
    press_key(1'b1, 1'b0, 20);
    settle("next_wrap");
    check_int("next_wrap_mode", int'(vpg_mode), 0);
    p0 = chg_pulses;
    do_force(12);
    repeat (10) step();
    check_int("force_oor_mode", int'(vpg_mode), 0);
    check_int("force_oor_pulses", chg_pulses - p0, 0);
    do_force(0);
    repeat (10) step();
    check_int("force_same_pulses", chg_pulses - p0, 0);
  endtask

  task automatic test_same_cycle();
    int p0;
    int waited;
    p0 = chg_pulses;
    press_key(1'b1, 1'b1, 20);
    check_int("both_keys_mode", int'(vpg_mode), 0);
    check_int("both_keys_pulses", chg_pulses - p0, 0);
    waited = 0;
    while (tick_en !== 1'b1 && waited < 2 * CLK_DIV) begin
      step();
      waited++;
    end
    check_int("tick_align", int'(tick_en), 1);
    btn_next_n = 1'b0;
    repeat (12) step();
    do_force(5);
    repeat (10) step();
    btn_next_n = 1'b1;
    repeat (24) step();
    settle("force_vs_next");
    check_int("force_vs_next_mode", int'(vpg_mode), 5);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = chg_pulses;
    do_force(3);
    do_force(4);
    repeat (12) step();
    check_int("b2b_mode", int'(vpg_mode), 4);
    check_int("b2b_pulses", chg_pulses - p0, 1);
    check_int("b2b_strobe_len", last_chg_len, 7);
  endtask

  task automatic test_reset_mid_hold();
    int lat;
    do_force(7);
    step();
    #2;
    reset_n = 1'b0;
    btn_next_n = 1'b0;
    #1;
    check_int("async_reset_mode", int'(vpg_mode), RESET_MODE);
    check_int("async_reset_change", int'(vpg_mode_change), 0);
    exp_q.delete();
    exp_mode = RESET_MODE;
    repeat (3) step();
    reset_n = 1'b1;
    model_press(1'b1, 1'b0);
    lat = 0;
    while (vpg_mode === MODE_W'(RESET_MODE) && lat < 40) begin
      step();
      lat++;
    end
    repeat (30) step();
    btn_next_n = 1'b1;
    repeat (24) step();
    settle("held_through_reset");
    check_int("held_through_reset_mode", int'(vpg_mode), 1);
  endtask

  initial begin
    test_reset();
    test_hold_next();
    test_glitch_and_prev_wrap();
    test_force_wrap();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_hold();
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
